cmplx_frame_accumulator: RTL and testbench
==========================================

// Module: cmplx_frame_accumulator
// PURPOSE
//   Sits directly downstream of the complex multiplier stage and consumes its registered
//   c_r/c_i product stream. Sums LEN consecutive accepted products per frame
//   (complex dot-product / correlation tap) at full internal precision.
//   Presents one saturated complex result per frame on a valid/ready output.
// PARAMETERS
//   N      8   operand width of upstream multiplier; product inputs are 2*N bits signed
//   LEN    4   products per frame, >= 2
//   OUT_W  17  output width, signed, saturating; 2*N <= OUT_W <= 2*N+$clog2(LEN)
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   clr        in   1        sync abort: discard partial frame
//   in_valid   in   1        product sample valid
//   in_ready   out  1        sample accepted when in_valid & in_ready
//   in_r       in   2*N      signed real product (from c_r)
//   in_i       in   2*N      signed imag product (from c_i)
//   out_valid  out  1        frame result valid
//   out_ready  in   1        downstream accepts when out_valid & out_ready
//   out_r      out  OUT_W    signed saturated real sum
//   out_i      out  OUT_W    signed saturated imag sum
//   out_sat    out  1        either component clipped in this result
// BEHAVIOUR
//   - Reset (async assert, sync-released use): acc_r/acc_i=0, cnt=0, out_valid=0,
//     out_r=out_i=0, out_sat=0. Reset mid-frame drops partial sum and any pending result.
//   - acc_r/acc_i width ACC_W=2*N+$clog2(LEN), sign-extended adds; never overflows.
//   - cnt 0..LEN-1 = samples accepted in current frame. FSM states implicit in cnt/out_valid:
//     FILL (cnt<LEN-1), LAST (cnt==LEN-1), each with output EMPTY/PENDING.
//   - in_ready = !clr & !(cnt==LEN-1 & out_valid & !out_ready) (comb; out_ready path).
//   - Accept, cnt<LEN-1: acc+=in, cnt++.
//   - Accept, cnt==LEN-1: sum=acc+in; out_r/out_i=sat(sum), out_sat set, out_valid=1 next
//     cycle; acc=0, cnt=0 same edge. Latency: result visible 1 cycle after last accept edge.
//   - sat(x): x>2^(OUT_W-1)-1 -> max; x<-2^(OUT_W-1) -> min; else x. Per component.
//   - in_valid low: no state change (bubbles allowed anywhere in frame).
//   - Output hold: while out_valid & !out_ready, out_r/out_i/out_sat stable.
//     FILL-phase samples still accepted; only the LAST sample stalls.
//   - Handshake and new result on same edge: out_valid stays 1, new data loaded.
//   - Handshake with no new result: out_valid->0; data regs keep last value.
//   - clr: cnt=0, acc=0 next edge; sample in clr cycle dropped (in_ready=0);
//     pending output unaffected.
// TESTING (defaults N=8, LEN=4, OUT_W=17, out_ready=1 unless stated)
//   1 Four samples (100,-50), back-to-back -> one cycle after 4th accept: out=(400,-200),
//     out_sat=0, out_valid high exactly 1 cycle.
//   2 Four samples (32767,-32768) -> out_r=65535, out_i=-65536, out_sat=1;
//     next frame of (1,1) x4 -> (4,4), out_sat=0.
//   3 out_ready=0 after frame A=(400,-200); stream frame B -> 3 accepted, 4th in_ready=0,
//     out holds (400,-200); raise out_ready -> A taken, B accepted same edge, out=B next.
//   4 Samples with bubbles (valid 1,0,1,0,...) of (1,2),(3,4),(5,6),(7,8) -> out=(16,20).
//   5 Two samples (10,10), clr=1 with in_valid=1 (5,5), then four (1,-1) -> out=(4,-4).
//   6 rst_n low after 2 samples with result pending -> all outputs 0 immediately;
//     after release, 4 samples (2,3) -> out=(8,12).

Source files
------------

// File: rtl/cmplx_frame_accumulator.sv
// -----------------------------------------------------------------------------
// cmplx_frame_accumulator
//
// Consumes the registered complex product stream of the upstream multiplier
// and sums LEN accepted products per frame at full precision. One saturated
// complex result per frame is presented on a valid/ready output port.
//
// Parameters
//   N      operand width of the upstream multiplier (products are 2*N bits)
//   LEN    products per frame (>= 2)
//   OUT_W  signed output width, 2*N <= OUT_W <= 2*N+$clog2(LEN)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort, discards the partial frame
//   in_valid   product sample valid
//   in_ready   sample accepted when in_valid & in_ready
//   in_r/in_i  signed real / imaginary product, 2*N bits
//   out_valid  frame result valid
//   out_ready  downstream accepts when out_valid & out_ready
//   out_r/i    signed saturated real / imaginary frame sum, OUT_W bits
//   out_sat    either component clipped in the presented result
// -----------------------------------------------------------------------------
module cmplx_frame_accumulator #(
  parameter int N     = 8,
  parameter int LEN   = 4,
  parameter int OUT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_r,
  input  logic [2*N-1:0]   in_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_r,
  output logic [OUT_W-1:0] out_i,
  output logic             out_sat
);

  localparam int IN_W  = 2 * N;
  localparam int CNT_W = $clog2(LEN);
  // LEN products of IN_W bits need $clog2(LEN) guard bits, so the
  // accumulator can never wrap.
  localparam int ACC_W = IN_W + CNT_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  // Frame phase is implied by the sample count; the output side is implied
  // by out_valid (EMPTY / PENDING).
  typedef enum logic {
    PH_FILL,
    PH_LAST
  } phase_e;

  phase_e                  phase;
  logic                    accept;
  logic                    finish;

  logic signed [ACC_W-1:0] acc_r_q, acc_i_q;
  logic signed [ACC_W-1:0] acc_r_d, acc_i_d;
  logic signed [ACC_W-1:0] sum_r, sum_i;
  logic        [CNT_W-1:0] cnt_q, cnt_d;

  logic                    out_valid_d;
  logic        [OUT_W-1:0] out_r_d, out_i_d;
  logic                    out_sat_d;

  logic        [OUT_W-1:0] sat_r_val, sat_i_val;
  logic                    sat_r_clip, sat_i_clip;

  // Returns {clipped, value} for one component.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] x);
    if (x > SAT_MAX) begin
      return {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (x < SAT_MIN) begin
      return {1'b1, SAT_MIN[OUT_W-1:0]};
    end else begin
      return {1'b0, x[OUT_W-1:0]};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and handshake logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    phase       = (cnt_q == CNT_LAST) ? PH_LAST : PH_FILL;
    acc_r_d     = acc_r_q;
    acc_i_d     = acc_i_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid;
    out_r_d     = out_r;
    out_i_d     = out_i;
    out_sat_d   = out_sat;

    // Only the frame-completing sample has to wait for the output register;
    // fill-phase samples keep flowing while a result is pending.
    in_ready = !clr && !(phase == PH_LAST && out_valid && !out_ready);
    accept   = in_valid && in_ready;
    finish   = accept && (phase == PH_LAST);

    sum_r = acc_r_q + {{CNT_W{in_r[IN_W-1]}}, in_r};
    sum_i = acc_i_q + {{CNT_W{in_i[IN_W-1]}}, in_i};
    {sat_r_clip, sat_r_val} = saturate(sum_r);
    {sat_i_clip, sat_i_val} = saturate(sum_i);

    if (clr) begin
      acc_r_d = '0;
      acc_i_d = '0;
      cnt_d   = '0;
    end else if (accept) begin
      if (phase == PH_LAST) begin
        acc_r_d   = '0;
        acc_i_d   = '0;
        cnt_d     = '0;
        out_r_d   = sat_r_val;
        out_i_d   = sat_i_val;
        out_sat_d = sat_r_clip | sat_i_clip;
      end else begin
        acc_r_d = sum_r;
        acc_i_d = sum_i;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end

    // A new result takes priority over retiring the old one, so a handshake
    // coinciding with a completing frame keeps out_valid high.
    if (finish) begin
      out_valid_d = 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r_q   <= '0;
      acc_i_q   <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_sat   <= 1'b0;
    end else begin
      acc_r_q   <= acc_r_d;
      acc_i_q   <= acc_i_d;
      cnt_q     <= cnt_d;
      out_valid <= out_valid_d;
      out_r     <= out_r_d;
      out_i     <= out_i_d;
      out_sat   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_cmplx_frame_accumulator.sv
// -----------------------------------------------------------------------------
// tb_cmplx_frame_accumulator
//
// Directed scenarios followed by a randomized phase. A reference model keeps
// the samples of the current frame in queues, sums them with plain integer
// arithmetic when a frame completes, saturates the result and pushes it into
// a scoreboard. A separate monitor compares whatever the DUT presents against
// the scoreboard head, and pops it on the output handshake.
// -----------------------------------------------------------------------------
module tb_cmplx_frame_accumulator;

  localparam int N     = 8;
  localparam int LEN   = 4;
  localparam int OUT_W = 17;
  localparam int IN_W  = 2 * N;

  localparam longint OUT_MAX = (longint'(1) <<< (OUT_W - 1)) - 1;
  localparam longint OUT_MIN = -(longint'(1) <<< (OUT_W - 1));

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    clr;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_r, in_i;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_r, out_i;
  logic                    out_sat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint r;
    longint i;
    bit     s;
  } result_t;

  result_t sb[$];
  int      fr_r[$];
  int      fr_i[$];
  bit      m_pend;

  cmplx_frame_accumulator #(
    .N    (N),
    .LEN  (LEN),
    .OUT_W(OUT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_r     (in_r),
    .in_i     (in_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_r    (out_r),
    .out_i    (out_i),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint x, output bit clipped);
    clipped = 1'b0;
    if (x > OUT_MAX) begin
      clipped = 1'b1;
      return OUT_MAX;
    end
    if (x < OUT_MIN) begin
      clipped = 1'b1;
      return OUT_MIN;
    end
    return x;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: evaluated mid-cycle on the values the next rising edge
  // will see; its state afterwards describes the DUT after that edge.
  // ---------------------------------------------------------------------------
  bit      m_last, m_rdy, m_acc, m_new;
  longint  m_sr, m_si;
  bit      m_cr, m_ci;
  result_t m_res;

  always @(negedge clk) begin
    if (!rst_n) begin
      fr_r.delete();
      fr_i.delete();
      sb.delete();
      m_pend = 1'b0;
    end else begin
      m_last = (fr_r.size() == LEN - 1);
      m_rdy  = !clr && !(m_last && m_pend && !out_ready);
      check("in_ready", longint'(in_ready), longint'(m_rdy));
      check("out_valid", longint'(out_valid), longint'(m_pend));
      m_acc = in_valid && m_rdy;
      m_new = 1'b0;
      if (clr) begin
        fr_r.delete();
        fr_i.delete();
      end else if (m_acc) begin
        fr_r.push_back(int'(in_r));
        fr_i.push_back(int'(in_i));
        if (fr_r.size() == LEN) begin
          m_sr = 0;
          m_si = 0;
          foreach (fr_r[k]) m_sr += fr_r[k];
          foreach (fr_i[k]) m_si += fr_i[k];
          m_res.r = sat(m_sr, m_cr);
          m_res.i = sat(m_si, m_ci);
          m_res.s = m_cr | m_ci;
          sb.push_back(m_res);
          fr_r.delete();
          fr_i.delete();
          m_new = 1'b1;
        end
      end
      if (m_new) m_pend = 1'b1;
      else if (m_pend && out_ready) m_pend = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares every presented result (including held cycles) against
  // the scoreboard head and retires it on the handshake.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got (%0d,%0d) expected none at %0t",
                 out_r, out_i, $time);
      end else begin
        check("out_r", longint'(out_r), sb[0].r);
        check("out_i", longint'(out_i), sb[0].i);
        check("out_sat", longint'(out_sat), longint'(sb[0].s));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input int i, input int gap);
    int waitc;
    waitc    = 0;
    in_valid = 1'b1;
    in_r     = r[IN_W-1:0];
    in_i     = i[IN_W-1:0];
    @(negedge clk);
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", waitc);
    end
    step();
    in_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_out_valid"}, longint'(out_valid), 0);
    check({tag, "_out_r"}, longint'(out_r), 0);
    check({tag, "_out_i"}, longint'(out_i), 0);
    check({tag, "_out_sat"}, longint'(out_sat), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_r      = '0;
    in_i      = '0;
    out_ready = 1'b1;
    #1;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // 1: plain frame, back-to-back
    for (int k = 0; k < LEN; k++) send(100, -50, 0);
    idle(3);

    // 2: saturation, then a small frame clearing out_sat
    for (int k = 0; k < LEN; k++) send(32767, -32768, 0);
    for (int k = 0; k < LEN; k++) send(1, 1, 0);
    idle(3);

    // 3: output back-pressure with a second frame streaming in
    out_ready = 1'b0;
    for (int k = 0; k < LEN; k++) send(100, -50, 0);
    for (int k = 0; k < LEN - 1; k++) send(7, 9, 0);
    in_valid = 1'b1;
    in_r     = 16'sd7;
    in_i     = 16'sd9;
    repeat (3) step();
    check("stall_in_ready", longint'(in_ready), 0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    idle(3);

    // 4: bubbles between samples
    send(1, 2, 1);
    send(3, 4, 1);
    send(5, 6, 1);
    send(7, 8, 1);
    idle(2);

    // 5: clr aborts a partial frame and drops its own sample
    send(10, 10, 0);
    send(10, 10, 0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_r     = 16'sd5;
    in_i     = 16'sd5;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < LEN; k++) send(1, -1, 0);
    idle(3);

    // 6: reset mid-frame with a result pending
    out_ready = 1'b0;
    for (int k = 0; k < LEN; k++) send(1, 1, 0);
    send(3, 3, 0);
    send(3, 3, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    for (int k = 0; k < LEN; k++) send(2, 3, 0);
    idle(3);

    // Randomized traffic: bubbles, back-pressure, aborts, extreme operands
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 40) == 0);
      case ($urandom_range(0, 3))
        0: begin
          in_r = 16'sh7fff;
          in_i = 16'sh8000;
        end
        1: begin
          in_r = 16'sh8000;
          in_i = 16'sh7fff;
        end
        default: begin
          in_r = IN_W'($urandom);
          in_i = IN_W'($urandom);
        end
      endcase
      step();
    end

    // Drain
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    check("scoreboard_drained", longint'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
